// File: rtl/csr_reg.sv
// Machine-mode CSR file: two write ports (execute, interrupt controller), two
// combinational read ports with write bypass, 64-bit mcycle and privilege level.
module csr_reg #(
    parameter logic [31:0] MHARTID = 32'h0,
    parameter logic [31:0] MISA    = 32'h40001100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_wr_en_i,
    input  logic [31:0] ex_wr_addr_i,
    input  logic [31:0] ex_wr_data_i,
    input  logic [31:0] ex_rd_addr_i,
    output logic [31:0] ex_rd_data_o,
    input  logic        clint_wr_en_i,
    input  logic [31:0] clint_wr_addr_i,
    input  logic [31:0] clint_wr_data_i,
    input  logic [31:0] clint_rd_addr_i,
    output logic [31:0] clint_rd_data_o,
    input  logic        clint_wr_privilege_en_i,
    input  logic [1:0]  clint_wr_privilege_i,
    output logic [1:0]  privilege_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mstatus_o,
    output logic        global_int_en_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0] mcycle_q;
    logic [1:0]  priv_q;

    logic [11:0] ex_wa, cl_wa;
    logic [32:0] w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause;
    logic [32:0] w_mcycle, w_mcycleh;
    logic        unused_addr_bits;

    assign ex_wa = ex_wr_addr_i[11:0];
    assign cl_wa = clint_wr_addr_i[11:0];
    assign unused_addr_bits = ^{ex_wr_addr_i[31:12], clint_wr_addr_i[31:12],
                                ex_rd_addr_i[31:12], clint_rd_addr_i[31:12]};

    function automatic logic is_writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MCYCLE, A_MCYCLEH: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // {hit, data}: pending write to address a this cycle, clint port taking priority
    function automatic logic [32:0] pick_wr(input logic [11:0] a);
        logic        hit;
        logic [31:0] d;
        hit = 1'b1;
        d   = '0;
        if (clint_wr_en_i && cl_wa == a)
            d = clint_wr_data_i;
        else if (ex_wr_en_i && ex_wa == a)
            d = ex_wr_data_i;
        else
            hit = 1'b0;
        if (a == A_MEPC)
            d[0] = 1'b0;
        return {hit, d};
    endfunction

    function automatic logic [31:0] read_stored(input logic [11:0] a);
        case (a)
            A_MSTATUS:           return mstatus_q;
            A_MISA:              return MISA;
            A_MIE:               return mie_q;
            A_MTVEC:             return mtvec_q;
            A_MSCRATCH:          return mscratch_q;
            A_MEPC:              return mepc_q;
            A_MCAUSE:            return mcause_q;
            A_MCYCLE, A_CYCLE:   return mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH: return mcycle_q[63:32];
            A_MHARTID:           return MHARTID;
            default:             return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] read_port(input logic [11:0] a);
        logic [32:0] pw;
        pw = pick_wr(a);
        if (is_writable(a) && pw[32])
            return pw[31:0];
        return read_stored(a);
    endfunction

    always_comb begin
        w_mstatus  = pick_wr(A_MSTATUS);
        w_mie      = pick_wr(A_MIE);
        w_mtvec    = pick_wr(A_MTVEC);
        w_mscratch = pick_wr(A_MSCRATCH);
        w_mepc     = pick_wr(A_MEPC);
        w_mcause   = pick_wr(A_MCAUSE);
        w_mcycle   = pick_wr(A_MCYCLE);
        w_mcycleh  = pick_wr(A_MCYCLEH);
    end

    always_comb begin
        ex_rd_data_o    = read_port(ex_rd_addr_i[11:0]);
        clint_rd_data_o = read_port(clint_rd_addr_i[11:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            priv_q     <= 2'b11;
        end else begin
            if (w_mstatus[32])  mstatus_q  <= w_mstatus[31:0];
            if (w_mie[32])      mie_q      <= w_mie[31:0];
            if (w_mtvec[32])    mtvec_q    <= w_mtvec[31:0];
            if (w_mscratch[32]) mscratch_q <= w_mscratch[31:0];
            if (w_mepc[32])     mepc_q     <= w_mepc[31:0];
            if (w_mcause[32])   mcause_q   <= w_mcause[31:0];
            // A write to either half suspends counting; the untouched half holds
            if (w_mcycle[32] || w_mcycleh[32]) begin
                if (w_mcycle[32])  mcycle_q[31:0]  <= w_mcycle[31:0];
                if (w_mcycleh[32]) mcycle_q[63:32] <= w_mcycleh[31:0];
            end else begin
                mcycle_q <= mcycle_q + 64'd1;
            end
            if (clint_wr_privilege_en_i &&
                (clint_wr_privilege_i == 2'b11 || clint_wr_privilege_i == 2'b00))
                priv_q <= clint_wr_privilege_i;
        end
    end

    assign privilege_o     = priv_q;
    assign csr_mtvec_o     = mtvec_q;
    assign csr_mepc_o      = mepc_q;
    assign csr_mstatus_o   = mstatus_q;
    assign global_int_en_o = mstatus_q[3];

endmodule

// File: tb/tb_csr_reg.sv
// Directed bench for csr_reg: expected values are queued when stimulus is
// driven and checked against DUT outputs when they become observable.
module tb_csr_reg;

    localparam logic [31:0] HART = 32'h0000_0005;
    localparam logic [31:0] ISA  = 32'h4000_1100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_wr_en;
    logic [31:0] ex_wr_addr, ex_wr_data, ex_rd_addr, ex_rd_data;
    logic        clint_wr_en;
    logic [31:0] clint_wr_addr, clint_wr_data, clint_rd_addr, clint_rd_data;
    logic        priv_en;
    logic [1:0]  priv_in, privilege;
    logic [31:0] mtvec, mepc, mstatus;
    logic        gie;

    csr_reg #(.MHARTID(HART), .MISA(ISA)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .ex_wr_en_i              (ex_wr_en),
        .ex_wr_addr_i            (ex_wr_addr),
        .ex_wr_data_i            (ex_wr_data),
        .ex_rd_addr_i            (ex_rd_addr),
        .ex_rd_data_o            (ex_rd_data),
        .clint_wr_en_i           (clint_wr_en),
        .clint_wr_addr_i         (clint_wr_addr),
        .clint_wr_data_i         (clint_wr_data),
        .clint_rd_addr_i         (clint_rd_addr),
        .clint_rd_data_o         (clint_rd_data),
        .clint_wr_privilege_en_i (priv_en),
        .clint_wr_privilege_i    (priv_in),
        .privilege_o             (privilege),
        .csr_mtvec_o             (mtvec),
        .csr_mepc_o              (mepc),
        .csr_mstatus_o           (mstatus),
        .global_int_en_o         (gie)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_q.push_back('{tag, exp});
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_item_t it;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required a queued entry", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_wr_en = 1'b0; clint_wr_en = 1'b0; priv_en = 1'b0;
    endtask

    task automatic ex_wr(input logic [31:0] a, input logic [31:0] d);
        ex_wr_en = 1'b1; ex_wr_addr = a; ex_wr_data = d;
    endtask

    task automatic cl_wr(input logic [31:0] a, input logic [31:0] d);
        clint_wr_en = 1'b1; clint_wr_addr = a; clint_wr_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        ex_wr_addr = '0; ex_wr_data = '0; ex_rd_addr = '0;
        clint_wr_addr = '0; clint_wr_data = '0; clint_rd_addr = '0;
        priv_in = 2'b00;

        // Reset state
        tick(); tick();
        ex_rd_addr = 32'hB00; #1;
        push("rst_mtvec", 32'h0);   chk(mtvec);
        push("rst_mepc", 32'h0);    chk(mepc);
        push("rst_mstatus", 32'h0); chk(mstatus);
        push("rst_gie", 32'h0);     chk({31'b0, gie});
        push("rst_priv", 32'h3);    chk({30'b0, privilege});
        push("rst_mcycle", 32'h0);  chk(ex_rd_data);

        // Count from 0 after release: three edges -> 3
        rst_n = 1'b1;
        tick(); tick(); tick();
        ex_rd_addr = 32'hC00; clint_rd_addr = 32'hC80; #1;
        push("cycle_lo", 32'd3); chk(ex_rd_data);
        push("cycle_hi", 32'd0); chk(clint_rd_data);
        ex_rd_addr = 32'h301; clint_rd_addr = 32'hF14; #1;
        push("misa", ISA);     chk(ex_rd_data);
        push("mhartid", HART); chk(clint_rd_data);

        // mtvec write: same-cycle bypass, register output one cycle later
        ex_wr(32'h305, 32'h100); ex_rd_addr = 32'h305; #1;
        push("mtvec_bypass", 32'h100); chk(ex_rd_data);
        push("mtvec_o_pre", 32'h0);    chk(mtvec);
        tick(); idle(); #1;
        push("mtvec_o", 32'h100);      chk(mtvec);

        // Same-address collision on mepc: clint wins, bit 0 cleared
        ex_wr(32'h341, 32'h10); cl_wr(32'h341, 32'h21);
        ex_rd_addr = 32'h341; clint_rd_addr = 32'h341; #1;
        push("mepc_byp_ex", 32'h20); chk(ex_rd_data);
        push("mepc_byp_cl", 32'h20); chk(clint_rd_data);
        tick(); idle(); #1;
        push("mepc_o", 32'h20);      chk(mepc);
        push("mepc_rd", 32'h20);     chk(ex_rd_data);

        // Different addresses written by both ports in one cycle
        ex_wr(32'h340, 32'h0000_AAAA); cl_wr(32'h342, 32'h8000_000B);
        tick(); idle();
        ex_rd_addr = 32'h340; clint_rd_addr = 32'h342; #1;
        push("mscratch", 32'h0000_AAAA); chk(ex_rd_data);
        push("mcause", 32'h8000_000B);   chk(clint_rd_data);

        // mcycle wrap
        ex_wr(32'hB80, 32'hFFFF_FFFF);
        tick();
        ex_wr(32'hB00, 32'hFFFF_FFFF);
        tick(); idle();
        ex_rd_addr = 32'hB00; clint_rd_addr = 32'hB80; #1;
        push("mcycle_lo_set", 32'hFFFF_FFFF); chk(ex_rd_data);
        push("mcycle_hi_set", 32'hFFFF_FFFF); chk(clint_rd_data);
        tick();
        push("mcycle_lo_wrap", 32'h0); chk(ex_rd_data);
        push("mcycle_hi_wrap", 32'h0); chk(clint_rd_data);

        // Trap-style mstatus sequence and privilege handling
        cl_wr(32'h300, 32'h0000_1800); priv_en = 1'b1; priv_in = 2'b11;
        tick();
        cl_wr(32'h300, 32'h0000_0008); priv_en = 1'b0; #1;
        push("gie_pre", 32'h0); chk({31'b0, gie});
        tick(); idle(); #1;
        push("gie", 32'h1);          chk({31'b0, gie});
        push("mstatus_o", 32'h8);    chk(mstatus);
        priv_en = 1'b1; priv_in = 2'b00;
        tick(); #1;
        push("priv_user", 32'h0);    chk({30'b0, privilege});
        priv_in = 2'b10;
        tick(); #1;
        push("priv_ign10", 32'h0);   chk({30'b0, privilege});
        priv_in = 2'b01;
        tick(); idle(); #1;
        push("priv_ign01", 32'h0);   chk({30'b0, privilege});

        // Read-only and undecoded addresses are never bypassed
        ex_wr(32'hF14, 32'h0000_DEAD); ex_rd_addr = 32'hF14;
        cl_wr(32'h7C0, 32'h1234_5678); clint_rd_addr = 32'h7C0; #1;
        push("mhartid_ro_byp", HART); chk(ex_rd_data);
        push("undec_byp", 32'h0);     chk(clint_rd_data);
        tick(); idle(); #1;
        push("mhartid_ro", HART);     chk(ex_rd_data);
        push("undec_rd", 32'h0);      chk(clint_rd_data);

        // Reset mid-operation overrides a simultaneous mie write
        ex_wr(32'h304, 32'h555);
        tick();
        rst_n = 1'b0; ex_wr(32'h304, 32'h888);
        tick();
        rst_n = 1'b1; idle();
        ex_rd_addr = 32'h304; clint_rd_addr = 32'hB00; #1;
        push("rst2_mie", 32'h0);    chk(ex_rd_data);
        push("rst2_mcycle", 32'h0); chk(clint_rd_data);
        push("rst2_priv", 32'h3);   chk({30'b0, privilege});
        push("rst2_mstatus", 32'h0); chk(mstatus);
        tick();
        push("rst2_mcycle_run", 32'h1); chk(clint_rd_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
